txt_rom_arbiter: RTL and testbench

//  Round-robin arbiter that shares one text-ROM lookup port among NREQ draw requesters
//  (e.g. overlay, score, menu layers). Each accepted request carries a char position and a

---
 rtl/txt_rom_arbiter.sv | 130 +++++++++++++
 tb/tb_txt_rom_arbiter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/txt_rom_arbiter.sv
// Round-robin arbiter sharing one text-ROM lookup port among NREQ draw requesters.
// Optional owner lock for burst line reads: define TXT_ARB_LOCK_EN.
module txt_rom_arbiter #(
    parameter int NREQ    = 4,
    parameter int ROM_LAT = 1,
    parameter int MSG_W   = 3,
    localparam int IDW    = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*8-1:0]     req_xy,
    input  logic [NREQ*MSG_W-1:0] req_msg,
`ifdef TXT_ARB_LOCK_EN
    input  logic [NREQ-1:0]       req_lock,
`endif
    output logic [NREQ-1:0]       req_ready,
    output logic [7:0]            rom_xy,
    output logic [MSG_W-1:0]      rom_msg,
    input  logic [6:0]            rom_char,
    output logic                  rsp_valid,
    output logic [6:0]            rsp_char,
    output logic [IDW-1:0]        rsp_id
);

    typedef struct packed {
        logic           vld;
        logic [IDW-1:0] id;
    } tag_t;

    logic [IDW-1:0] ptr;
    logic [IDW-1:0] winner;
    logic [IDW:0]   scan;
    logic           found;
    logic [IDW-1:0] grant_id;
    logic           grant;
    logic           accept;
    logic           lock_hit;
    logic [IDW-1:0] ptr_next;
    tag_t           tag_pipe [ROM_LAT+1];

    // Rotating priority scan starting at ptr.
    // NOTE: combinational blocks use blocking '=' and assign every output a default
    // first, so no latch is inferred and later loop iterations see earlier results.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        scan   = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan = {1'b0, ptr} + (IDW+1)'(k);
            if (scan >= (IDW+1)'(NREQ)) scan = scan - (IDW+1)'(NREQ);
            if (!found && req_valid[scan[IDW-1:0]]) begin
                found  = 1'b1;
                winner = scan[IDW-1:0];
            end
        end
    end

`ifdef TXT_ARB_LOCK_EN
    logic [IDW-1:0] owner;
    logic           owner_vld;

    // The last winner keeps the port while it holds both valid and lock.
    assign lock_hit = owner_vld && req_valid[owner] && req_lock[owner];
    assign grant_id = lock_hit ? owner : winner;
    assign grant    = lock_hit || found;

    always_ff @(posedge clk) begin
        if (rst) begin
            owner     <= '0;
            owner_vld <= 1'b0;
        end else if (accept) begin
            owner     <= grant_id;
            owner_vld <= 1'b1;
        end
    end
`else
    assign lock_hit = 1'b0;
    assign grant_id = winner;
    assign grant    = found;
`endif

    assign accept   = grant && en && !rst;
    assign ptr_next = (grant_id == IDW'(NREQ-1)) ? '0 : grant_id + 1'b1;

    always_comb begin
        req_ready           = '0;
        req_ready[grant_id] = accept;
    end

    // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr     <= '0;
            rom_xy  <= '0;
            rom_msg <= '0;
        end else if (accept) begin
            rom_xy  <= req_xy[8*grant_id +: 8];
            rom_msg <= req_msg[MSG_W*grant_id +: MSG_W];
            if (!lock_hit) ptr <= ptr_next;
        end
    end

    // Tag pipe tracks lookups in flight so each char returns with its owner.
    // NOTE: this small pipe is reset (unlike a RAM) because reset must flush in-flight lookups.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k <= ROM_LAT; k++) tag_pipe[k] <= '0;
        end else begin
            tag_pipe[0] <= '{vld: accept, id: grant_id};
            for (int k = 1; k <= ROM_LAT; k++) tag_pipe[k] <= tag_pipe[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_char  <= 7'h20;
            rsp_id    <= '0;
        end else begin
            rsp_valid <= tag_pipe[ROM_LAT].vld;
            if (tag_pipe[ROM_LAT].vld) begin
                rsp_char <= rom_char;
                rsp_id   <= tag_pipe[ROM_LAT].id;
            end
        end
    end

endmodule

// File: tb/tb_txt_rom_arbiter.sv
// Scoreboard bench for txt_rom_arbiter: a rotation model predicts grants, and
// expected responses are queued with their due cycle for an independent monitor.
module tb_txt_rom_arbiter;

    localparam int NREQ    = 4;
    localparam int ROM_LAT = 1;
    localparam int MSG_W   = 3;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  en;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*8-1:0]     req_xy;
    logic [NREQ*MSG_W-1:0] req_msg;
    logic [NREQ-1:0]       req_ready;
    logic [7:0]            rom_xy;
    logic [MSG_W-1:0]      rom_msg;
    logic [6:0]            rom_char = '0;
    logic                  rsp_valid;
    logic [6:0]            rsp_char;
    logic [1:0]            rsp_id;

    txt_rom_arbiter #(.NREQ(NREQ), .ROM_LAT(ROM_LAT), .MSG_W(MSG_W)) dut (
        .clk(clk), .rst(rst), .en(en),
        .req_valid(req_valid), .req_xy(req_xy), .req_msg(req_msg),
        .req_ready(req_ready), .rom_xy(rom_xy), .rom_msg(rom_msg),
        .rom_char(rom_char), .rsp_valid(rsp_valid), .rsp_char(rsp_char), .rsp_id(rsp_id)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] rom_f(input logic [7:0] xy, input logic [2:0] msg);
        logic [7:0] s;
        s = 8'h41 + {4'h0, xy[3:0]} + {1'b0, msg, 4'h0};
        return s[6:0];
    endfunction

    // One-cycle-latency ROM bank model.
    always @(posedge clk) rom_char <= rom_f(rom_xy, rom_msg);

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        int         due;
        logic [6:0] ch;
        logic [1:0] id;
    } exp_t;

    exp_t exp_q[$];

    // Reference state
    int         m_ptr = 0;
    logic [7:0] m_xy  = '0;
    logic [2:0] m_msg = '0;
    logic       mon_on = 1'b0;

    // Monitor: compares every response against the queue head, and holds otherwise.
    logic [6:0] last_char = 7'h20;
    logic [1:0] last_id   = 2'd0;

    always @(negedge clk) begin
        if (mon_on) begin
            if (rsp_valid) begin
                check("rsp_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("rsp_cycle", cyc, e.due);
                    check("rsp_char", rsp_char, e.ch);
                    check("rsp_id", rsp_id, e.id);
                    last_char = e.ch;
                    last_id   = e.id;
                end
            end else begin
                if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
                    check("rsp_valid", rsp_valid, 1);
                    void'(exp_q.pop_front());
                end
                check("rsp_char_hold", rsp_char, last_char);
                check("rsp_id_hold", rsp_id, last_id);
            end
            if (rst) begin
                last_char = 7'h20;
                last_id   = 2'd0;
            end
        end
    end

    // Drive one cycle, predict the grant at mid-cycle, then advance to the next edge.
    task automatic step(input logic [3:0] v, input logic e, input logic r,
                        input logic [31:0] xy, input logic [11:0] msg);
        logic [3:0] exp_ready;
        int         w;
        bit         found;
        req_valid = v;
        en        = e;
        rst       = r;
        req_xy    = xy;
        req_msg   = msg;
        @(negedge clk);
        exp_ready = '0;
        found     = 0;
        w         = 0;
        if (!r && e) begin
            for (int k = 0; k < NREQ; k++) begin
                int idx;
                idx = (m_ptr + k) % NREQ;
                if (!found && v[idx]) begin
                    found = 1;
                    w     = idx;
                end
            end
        end
        if (found) exp_ready[w] = 1'b1;
        check("req_ready", req_ready, exp_ready);
        check("rom_xy", rom_xy, m_xy);
        check("rom_msg", rom_msg, m_msg);
        if (found) begin
            exp_q.push_back('{due: cyc + ROM_LAT + 2,
                              ch: rom_f(xy[8*w +: 8], msg[3*w +: 3]),
                              id: 2'(w)});
            m_xy  = xy[8*w +: 8];
            m_msg = msg[3*w +: 3];
            m_ptr = (w + 1) % NREQ;
        end
        if (r) begin
            m_ptr = 0;
            m_xy  = '0;
            m_msg = '0;
            while (exp_q.size() != 0 && exp_q[exp_q.size()-1].due > cyc) void'(exp_q.pop_back());
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rnd_xy();
        return $urandom;
    endfunction

    initial begin
        rst       = 1'b1;
        en        = 1'b1;
        req_valid = 4'hF;
        req_xy    = '0;
        req_msg   = '0;
        @(posedge clk);
        #1;
        mon_on = 1'b1;
        // Reset state with all requests pending
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_rsp_char", rsp_char, 7'h20);
        check("reset_ready", req_ready, 4'b0000);
        step(4'hF, 1, 1, rnd_xy(), '0);
        step(4'hF, 1, 1, rnd_xy(), '0);

        // Single request from req0, xy=04 -> char 0x45
        step(4'b0001, 1, 0, 32'h0000_0004, '0);
        repeat (4) step(4'b0000, 1, 0, rnd_xy(), '0);

        // All four valid: back-to-back rotation
        repeat (8) step(4'hF, 1, 0, rnd_xy(), '0);
        repeat (4) step(4'b0000, 1, 0, rnd_xy(), '0);

        // Move ptr to 2, then req1+req3 -> 3 first, then 1 (wrap)
        step(4'b0010, 1, 0, rnd_xy(), '0);
        repeat (2) step(4'b1010, 1, 0, rnd_xy(), '0);
        repeat (4) step(4'b0000, 1, 0, rnd_xy(), '0);

        // Enable gating, and responses still return after en falls
        repeat (3) step(4'b0100, 0, 0, rnd_xy(), '0);
        step(4'b0100, 1, 0, rnd_xy(), '0);
        step(4'b0001, 1, 0, rnd_xy(), '0);
        repeat (4) step(4'b1111, 0, 0, rnd_xy(), '0);

        // Accept then reset: the pending response must never appear
        step(4'b0010, 1, 0, rnd_xy(), '0);
        step(4'b1111, 1, 1, rnd_xy(), '0);
        repeat (4) step(4'b0000, 1, 0, rnd_xy(), '0);

        // Randomized traffic with mixed message ids, enable drops and occasional reset
        for (int i = 0; i < 400; i++) begin
            step(4'($urandom_range(0, 15)), ($urandom_range(0, 7) != 0),
                 ($urandom_range(0, 39) == 0), rnd_xy(), 12'($urandom));
        end
        repeat (6) step(4'b0000, 1, 0, rnd_xy(), '0);
        check("drain_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
